// File: rtl/matmul_pkg.sv
// Shared types and width helpers for the sequential fixed-point matrix multiplier.
package matmul_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_WAIT  = 3'd2,
        ST_MAC   = 3'd3,
        ST_OUT   = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    // Index port width: never narrower than one bit, even for a dimension of 1.
    function automatic int idx_w(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

    function automatic int acc_w(input int dw, input int k);
        return 2 * dw + $clog2(k) + 1;
    endfunction

endpackage

// File: rtl/seq_matmul_mac_if.sv
// Operand-memory read port and result stream of seq_matmul_mac, grouped as one bus.
interface seq_matmul_mac_if
    import matmul_pkg::*;
#(
    parameter int M  = 4,
    parameter int K  = 4,
    parameter int N  = 4,
    parameter int DW = 16,
    parameter int OW = acc_w(DW, K)
) ();
    localparam int IM = idx_w(M);
    localparam int IK = idx_w(K);
    localparam int IN = idx_w(N);

    logic                 a_rd;
    logic [IM-1:0]        a_i;
    logic [IK-1:0]        a_j;
    logic [IK-1:0]        b_i;
    logic [IN-1:0]        b_j;
    logic signed [DW-1:0] a_in;
    logic signed [DW-1:0] b_in;
    logic signed [OW-1:0] z_out;
    logic [IM-1:0]        z_i;
    logic [IN-1:0]        z_j;
    logic                 z_stb;
    logic                 z_ack;
    logic                 z_sat;

    modport master (
        output a_rd, a_i, a_j, b_i, b_j, z_out, z_i, z_j, z_stb, z_sat,
        input  a_in, b_in, z_ack
    );

    modport slave (
        input  a_rd, a_i, a_j, b_i, b_j, z_out, z_i, z_j, z_stb, z_sat,
        output a_in, b_in, z_ack
    );
endinterface

// File: rtl/matmul_mac_acc.sv
// Signed multiply-accumulate register with clear/enable and a read-out of the updated sum.
// MATMUL_SAT_EN selects a clamping read-out when the result port is narrower than the sum.
module matmul_mac_acc #(
    parameter int DW = 16,
    parameter int AW = 34,
    parameter int OW = 34
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 en,
    input  logic signed [DW-1:0] a,
    input  logic signed [DW-1:0] b,
    output logic signed [OW-1:0] rd_val,
    output logic                 rd_sat
);
    logic signed [2*DW-1:0] prod_s;
    logic signed [AW-1:0]   sum_s;
    logic signed [AW-1:0]   acc_r;

    assign prod_s = (2*DW)'(a) * (2*DW)'(b);
    assign sum_s  = acc_r + AW'(prod_s);

    // Accumulator: cleared at the start of each element, updated on every MAC cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_r <= AW'(0);
        end else if (clr) begin
            acc_r <= AW'(0);
        end else if (en) begin
            acc_r <= sum_s;
        end else begin
            acc_r <= acc_r;
        end
    end

`ifdef MATMUL_SAT_EN
    generate
        if (OW < AW) begin : g_clamp
            localparam logic signed [AW-1:0] HI_C = {{(AW-OW+1){1'b0}}, {(OW-1){1'b1}}};
            localparam logic signed [AW-1:0] LO_C = {{(AW-OW+1){1'b1}}, {(OW-1){1'b0}}};

            // Clamp the updated sum into the signed range of the result port
            always_comb begin
                rd_val = OW'(sum_s);
                rd_sat = 1'b0;
                if (sum_s > HI_C) begin
                    rd_val = {1'b0, {(OW-1){1'b1}}};
                    rd_sat = 1'b1;
                end else if (sum_s < LO_C) begin
                    rd_val = {1'b1, {(OW-1){1'b0}}};
                    rd_sat = 1'b1;
                end else begin
                    rd_val = OW'(sum_s);
                    rd_sat = 1'b0;
                end
            end
        end else begin : g_pass
            assign rd_val = OW'(sum_s);
            assign rd_sat = 1'b0;
        end
    endgenerate
`else
    // Narrow ports keep the low bits; wide ports sign-extend.
    assign rd_val = OW'(sum_s);
    assign rd_sat = 1'b0;
`endif

endmodule

// File: rtl/seq_matmul_mac.sv
// Sequential Z = A*B on signed fixed-point operands read from external synchronous RAMs.
// Optional clamping of results is compiled in with MATMUL_SAT_EN.
module seq_matmul_mac
    import matmul_pkg::*;
#(
    parameter int M      = 4,
    parameter int K      = 4,
    parameter int N      = 4,
    parameter int DW     = 16,
    parameter int OW     = acc_w(DW, K),
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    seq_matmul_mac_if.master  bus,
    output logic              busy,
    output logic              done
);
    localparam int IM = idx_w(M);
    localparam int IK = idx_w(K);
    localparam int IN = idx_w(N);
    localparam int AW = acc_w(DW, K);
    localparam int WW = idx_w(RD_LAT);

    localparam logic [IM-1:0] M_LAST  = IM'(M - 1);
    localparam logic [IK-1:0] K_LAST  = IK'(K - 1);
    localparam logic [IN-1:0] N_LAST  = IN'(N - 1);
    localparam logic [WW-1:0] WAIT_LD = WW'((RD_LAT > 1) ? (RD_LAT - 2) : 0);

    state_t               state_r;
    logic [IM-1:0]        i_r;
    logic [IN-1:0]        j_r;
    logic [IK-1:0]        k_r;
    logic [WW-1:0]        wait_r;
    logic                 a_rd_r;
    logic signed [OW-1:0] z_out_r;
    logic [IM-1:0]        z_i_r;
    logic [IN-1:0]        z_j_r;
    logic                 z_stb_r;
    logic                 z_sat_r;
    logic                 busy_r;
    logic                 done_r;
    logic                 clr_s;
    logic                 en_s;
    logic signed [OW-1:0] rd_val_s;
    logic                 rd_sat_s;

    // Accumulator is cleared on a fresh start and after each accepted element
    always_comb begin
        clr_s = 1'b0;
        en_s  = 1'b0;
        if (state_r == ST_IDLE) begin
            clr_s = start;
        end else if (state_r == ST_OUT) begin
            clr_s = bus.z_ack;
        end else begin
            en_s = (state_r == ST_MAC);
        end
    end

    matmul_mac_acc #(.DW(DW), .AW(AW), .OW(OW)) u_acc (
        .clk    (clk),
        .rst    (rst),
        .clr    (clr_s),
        .en     (en_s),
        .a      (bus.a_in),
        .b      (bus.b_in),
        .rd_val (rd_val_s),
        .rd_sat (rd_sat_s)
    );

    // Sequencer: fetch operands, accumulate, then hand each element to the sink
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            i_r     <= IM'(0);
            j_r     <= IN'(0);
            k_r     <= IK'(0);
            wait_r  <= WW'(0);
            a_rd_r  <= 1'b0;
            z_out_r <= OW'(0);
            z_i_r   <= IM'(0);
            z_j_r   <= IN'(0);
            z_stb_r <= 1'b0;
            z_sat_r <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            a_rd_r <= 1'b0;
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        i_r     <= IM'(0);
                        j_r     <= IN'(0);
                        k_r     <= IK'(0);
                        a_rd_r  <= 1'b1;
                        busy_r  <= 1'b1;
                        state_r <= ST_FETCH;
                    end else begin
                        busy_r  <= 1'b0;
                    end
                end
                ST_FETCH: begin
                    if (RD_LAT > 1) begin
                        wait_r  <= WAIT_LD;
                        state_r <= ST_WAIT;
                    end else begin
                        state_r <= ST_MAC;
                    end
                end
                ST_WAIT: begin
                    if (wait_r == WW'(0)) begin
                        state_r <= ST_MAC;
                    end else begin
                        wait_r  <= wait_r - WW'(1);
                    end
                end
                ST_MAC: begin
                    if (k_r != K_LAST) begin
                        k_r     <= k_r + IK'(1);
                        a_rd_r  <= 1'b1;
                        state_r <= ST_FETCH;
                    end else begin
                        z_out_r <= rd_val_s;
                        z_sat_r <= rd_sat_s;
                        z_i_r   <= i_r;
                        z_j_r   <= j_r;
                        z_stb_r <= 1'b1;
                        state_r <= ST_OUT;
                    end
                end
                ST_OUT: begin
                    if (bus.z_ack) begin
                        z_stb_r <= 1'b0;
                        z_sat_r <= 1'b0;
                        k_r     <= IK'(0);
                        // Row-major walk; both indices wrap to 0 after the last element
                        if (j_r == N_LAST) begin
                            j_r <= IN'(0);
                            i_r <= (i_r == M_LAST) ? IM'(0) : (i_r + IM'(1));
                        end else begin
                            j_r <= j_r + IN'(1);
                        end
                        if ((i_r == M_LAST) && (j_r == N_LAST)) begin
                            done_r  <= 1'b1;
                            state_r <= ST_DONE;
                        end else begin
                            a_rd_r  <= 1'b1;
                            state_r <= ST_FETCH;
                        end
                    end else begin
                        state_r <= ST_OUT;
                    end
                end
                ST_DONE: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    z_stb_r <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.a_rd  = a_rd_r;
    assign bus.a_i   = i_r;
    assign bus.a_j   = k_r;
    assign bus.b_i   = k_r;
    assign bus.b_j   = j_r;
    assign bus.z_out = z_out_r;
    assign bus.z_i   = z_i_r;
    assign bus.z_j   = z_j_r;
    assign bus.z_stb = z_stb_r;
    assign bus.z_sat = z_sat_r;
    assign busy      = busy_r;
    assign done      = done_r;

endmodule

// File: tb/tb_seq_matmul_mac.sv
// Directed bench for seq_matmul_mac: four instances covering the 2x2 identity product,
// read latency 3, signed extremes and narrow-output wrap/clamp (MATMUL_SAT_EN aware).
module tb_seq_matmul_mac;

    logic clk = 1'b0;
    logic rst;
    logic start_a, start_c, start_s, start_w;
    logic busy_a, busy_c, busy_s, busy_w;
    logic done_a, done_c, done_s, done_w;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    seq_matmul_mac_if #(.M(2), .K(2), .N(2), .DW(16), .OW(34)) ifa ();
    seq_matmul_mac_if #(.M(2), .K(2), .N(2), .DW(16), .OW(34)) ifc ();
    seq_matmul_mac_if #(.M(1), .K(2), .N(1), .DW(8),  .OW(18)) ifs ();
    seq_matmul_mac_if #(.M(1), .K(2), .N(1), .DW(8),  .OW(8))  ifw ();

    seq_matmul_mac #(.M(2), .K(2), .N(2), .DW(16), .OW(34), .RD_LAT(1)) u_a (
        .clk(clk), .rst(rst), .start(start_a), .bus(ifa), .busy(busy_a), .done(done_a));
    seq_matmul_mac #(.M(2), .K(2), .N(2), .DW(16), .OW(34), .RD_LAT(3)) u_c (
        .clk(clk), .rst(rst), .start(start_c), .bus(ifc), .busy(busy_c), .done(done_c));
    seq_matmul_mac #(.M(1), .K(2), .N(1), .DW(8), .OW(18), .RD_LAT(1)) u_s (
        .clk(clk), .rst(rst), .start(start_s), .bus(ifs), .busy(busy_s), .done(done_s));
    seq_matmul_mac #(.M(1), .K(2), .N(1), .DW(8), .OW(8), .RD_LAT(1)) u_w (
        .clk(clk), .rst(rst), .start(start_w), .bus(ifw), .busy(busy_w), .done(done_w));

    logic signed [15:0] a_mem [0:1][0:1];
    logic signed [15:0] b_mem [0:1][0:1];
    logic signed [7:0]  as_mem [0:1][0:1];
    logic signed [7:0]  bs_mem [0:1][0:1];
    logic signed [7:0]  aw_mem [0:1][0:1];
    logic signed [7:0]  bw_mem [0:1][0:1];
    logic signed [15:0] c_a1, c_a2, c_b1, c_b2;

    // Memory models: data appears RD_LAT cycles after a_rd, zero otherwise
    always @(posedge clk) begin
        ifa.a_in <= ifa.a_rd ? a_mem[ifa.a_i][ifa.a_j] : 16'sd0;
        ifa.b_in <= ifa.a_rd ? b_mem[ifa.b_i][ifa.b_j] : 16'sd0;
        c_a1     <= ifc.a_rd ? a_mem[ifc.a_i][ifc.a_j] : 16'sd0;
        c_b1     <= ifc.a_rd ? b_mem[ifc.b_i][ifc.b_j] : 16'sd0;
        c_a2     <= c_a1;
        c_b2     <= c_b1;
        ifc.a_in <= c_a2;
        ifc.b_in <= c_b2;
        ifs.a_in <= ifs.a_rd ? as_mem[ifs.a_i][ifs.a_j] : 8'sd0;
        ifs.b_in <= ifs.a_rd ? bs_mem[ifs.b_i][ifs.b_j] : 8'sd0;
        ifw.a_in <= ifw.a_rd ? aw_mem[ifw.a_i][ifw.a_j] : 8'sd0;
        ifw.b_in <= ifw.a_rd ? bw_mem[ifw.b_i][ifw.b_j] : 8'sd0;
    end

    int     ra_n, ra_done, ra_bad, ra_obs;
    int     ra_i [8];
    int     ra_j [8];
    longint ra_v [8];
    logic   ra_busy_after;

    // One product on instance A; holds ack low for hold_n cycles on element (0,1) and
    // pulses start at cycle pulse_at (0 = never). Cycle 1 is the one after the start edge.
    task automatic run_a(input int hold_n, input int pulse_at);
        longint cap_v;
        logic   is01;
        ra_n = 0; ra_done = 0; ra_bad = 0; ra_obs = 0; ra_busy_after = 1'b1; cap_v = 0;
        @(negedge clk);
        ifa.z_ack = 1'b0;
        start_a = 1'b1;
        @(posedge clk);
        for (int cyc = 1; cyc <= 200; cyc++) begin
            @(negedge clk);
            start_a = (cyc == pulse_at);
            if (done_a) begin
                ra_done = cyc;
                break;
            end
            if (ifa.z_stb) begin
                is01 = (ifa.z_i == 1'b0) && (ifa.z_j == 1'b1);
                if (is01) begin
                    if (ra_obs == 0) cap_v = ifa.z_out;
                    else if (ifa.z_out !== cap_v) ra_bad++;
                    ra_obs++;
                end
                if (is01 && (ra_obs <= hold_n)) begin
                    ifa.z_ack = 1'b0;
                end else begin
                    ifa.z_ack = 1'b1;
                    if (ra_n < 8) begin
                        ra_i[ra_n] = int'(ifa.z_i);
                        ra_j[ra_n] = int'(ifa.z_j);
                        ra_v[ra_n] = ifa.z_out;
                    end
                    ra_n++;
                end
            end else begin
                ifa.z_ack = 1'b0;
                if ((ra_obs > 0) && (ra_obs <= hold_n)) ra_bad++;
            end
            if (ifa.a_rd && (ra_obs > 0) && (ra_obs <= hold_n)) ra_bad++;
        end
        start_a = 1'b0;
        ifa.z_ack = 1'b0;
        if (ra_done > 0) begin
            @(negedge clk);
            ra_busy_after = busy_a;
        end
    endtask

    task automatic check_a_stream(input string tag, input int exp_done);
        longint exp_v [4];
        exp_v = '{64'sd1, 64'sd2, 64'sd3, 64'sd4};
        n_cmp++;
        if (ra_n !== 4) begin
            n_bad++; $display("FAIL %s_count: got %0d elements, expected 4", tag, ra_n);
        end
        for (int e = 0; e < 4; e++) begin
            n_cmp++;
            if ((ra_i[e] !== e / 2) || (ra_j[e] !== e % 2) || (ra_v[e] !== exp_v[e])) begin
                n_bad++;
                $display("FAIL %s_elem%0d: got (%0d,%0d)=%0d, expected (%0d,%0d)=%0d",
                         tag, e, ra_i[e], ra_j[e], ra_v[e], e / 2, e % 2, exp_v[e]);
            end
        end
        n_cmp++;
        if (ra_done !== exp_done) begin
            n_bad++; $display("FAIL %s_done_cycle: got %0d, expected %0d", tag, ra_done, exp_done);
        end
        n_cmp++;
        if (ra_busy_after !== 1'b0) begin
            n_bad++; $display("FAIL %s_busy_after_done: got %b, expected 0", tag, ra_busy_after);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start_a = 1'b0; start_c = 1'b0; start_s = 1'b0; start_w = 1'b0;
        ifa.z_ack = 1'b0; ifc.z_ack = 1'b0; ifs.z_ack = 1'b0; ifw.z_ack = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({ifa.a_rd, ifa.z_stb, ifa.z_sat, busy_a, done_a, ifa.a_i, ifa.a_j, ifa.b_i,
             ifa.b_j, ifa.z_i, ifa.z_j} !== 11'd0 || ifa.z_out !== 34'sd0) begin
            n_bad++; $display("FAIL reset_a: outputs not all zero (z_out=%0d busy=%b)", ifa.z_out, busy_a);
        end
        n_cmp++;
        if ({ifw.a_rd, ifw.z_stb, ifw.z_sat, busy_w, done_w} !== 5'd0 || ifw.z_out !== 8'sd0) begin
            n_bad++; $display("FAIL reset_w: outputs not all zero (z_out=%0d busy=%b)", ifw.z_out, busy_w);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_identity();
        run_a(0, 0);
        // Done in cycle M*N*(K*(RD_LAT+1)+1)+1 = 4*5+1 = 21
        check_a_stream("identity", 21);
    endtask

    task automatic test_backpressure();
        run_a(5, 0);
        n_cmp++;
        if (ra_bad !== 0) begin
            n_bad++; $display("FAIL bp_stable: %0d unstable/a_rd cycles, expected 0", ra_bad);
        end
        n_cmp++;
        if (ra_obs !== 6) begin
            n_bad++; $display("FAIL bp_strobe_cycles: got %0d, expected 6", ra_obs);
        end
        check_a_stream("bp", 26);
    endtask

    task automatic test_read_latency();
        int n, dc;
        int sc [4];
        longint v [4];
        n = 0; dc = 0;
        @(negedge clk);
        start_c = 1'b1;
        @(posedge clk);
        for (int cyc = 1; cyc <= 200; cyc++) begin
            @(negedge clk);
            start_c = 1'b0;
            if (done_c) begin dc = cyc; break; end
            ifc.z_ack = ifc.z_stb;
            if (ifc.z_stb) begin
                if (n < 4) begin sc[n] = cyc; v[n] = ifc.z_out; end
                n++;
            end
        end
        ifc.z_ack = 1'b0;
        n_cmp++;
        if (n !== 4) begin n_bad++; $display("FAIL lat3_count: got %0d, expected 4", n); end
        for (int e = 0; e < 4 && e < n; e++) begin
            n_cmp++;
            if ((v[e] !== longint'(e + 1)) || (sc[e] !== 9 * (e + 1))) begin
                n_bad++;
                $display("FAIL lat3_elem%0d: got %0d at cycle %0d, expected %0d at cycle %0d",
                         e, v[e], sc[e], e + 1, 9 * (e + 1));
            end
        end
        n_cmp++;
        if (dc !== 37) begin n_bad++; $display("FAIL lat3_done_cycle: got %0d, expected 37", dc); end
    endtask

    task automatic test_abort_restart();
        logic found;
        found = 1'b0;
        @(negedge clk);
        ifa.z_ack = 1'b1;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        for (int cyc = 0; cyc < 100; cyc++) begin
            @(negedge clk);
            if (ifa.a_rd && (ifa.a_i == 1'b1) && (ifa.a_j == 1'b0)) begin found = 1'b1; break; end
        end
        n_cmp++;
        if (found !== 1'b1) begin n_bad++; $display("FAIL abort_find_fetch10: got %b, expected 1", found); end
        @(negedge clk);
        rst = 1'b1;
        ifa.z_ack = 1'b0;
        #1;
        n_cmp++;
        if ({ifa.a_rd, ifa.z_stb, ifa.z_sat, busy_a, done_a, ifa.a_i, ifa.a_j, ifa.b_i,
             ifa.b_j, ifa.z_i, ifa.z_j} !== 11'd0 || ifa.z_out !== 34'sd0) begin
            n_bad++; $display("FAIL abort_outputs_zero: z_out=%0d busy=%b stb=%b", ifa.z_out, busy_a, ifa.z_stb);
        end
        @(negedge clk);
        rst = 1'b0;
        run_a(0, 4);
        check_a_stream("restart", 21);
    endtask

    task automatic test_signed();
        int dc;
        longint v;
        logic sat;
        dc = 0; v = 0; sat = 1'bx;
        @(negedge clk);
        start_s = 1'b1;
        @(posedge clk);
        for (int cyc = 1; cyc <= 50; cyc++) begin
            @(negedge clk);
            start_s = 1'b0;
            if (done_s) begin dc = cyc; break; end
            ifs.z_ack = ifs.z_stb;
            if (ifs.z_stb) begin v = ifs.z_out; sat = ifs.z_sat; end
        end
        ifs.z_ack = 1'b0;
        n_cmp++;
        if (v !== 64'sd32513) begin n_bad++; $display("FAIL signed_value: got %0d, expected 32513", v); end
        n_cmp++;
        if (sat !== 1'b0) begin n_bad++; $display("FAIL signed_sat: got %b, expected 0", sat); end
        n_cmp++;
        if (dc !== 6) begin n_bad++; $display("FAIL signed_done_cycle: got %0d, expected 6", dc); end
    endtask

    task automatic test_saturation();
        longint v, exp_v;
        logic sat, exp_sat;
`ifdef MATMUL_SAT_EN
        exp_v = 127; exp_sat = 1'b1;
`else
        exp_v = -56; exp_sat = 1'b0;
`endif
        v = 0; sat = 1'bx;
        @(negedge clk);
        start_w = 1'b1;
        @(posedge clk);
        for (int cyc = 1; cyc <= 50; cyc++) begin
            @(negedge clk);
            start_w = 1'b0;
            if (done_w) break;
            ifw.z_ack = ifw.z_stb;
            if (ifw.z_stb) begin v = ifw.z_out; sat = ifw.z_sat; end
        end
        ifw.z_ack = 1'b0;
        n_cmp++;
        if (v !== exp_v) begin n_bad++; $display("FAIL narrow_value: got %0d, expected %0d", v, exp_v); end
        n_cmp++;
        if (sat !== exp_sat) begin n_bad++; $display("FAIL narrow_sat: got %b, expected %b", sat, exp_sat); end
    endtask

    initial begin
        a_mem  = '{'{16'sd1, 16'sd2}, '{16'sd3, 16'sd4}};
        b_mem  = '{'{16'sd1, 16'sd0}, '{16'sd0, 16'sd1}};
        as_mem = '{'{-8'sd128, 8'sd127}, '{8'sd0, 8'sd0}};
        bs_mem = '{'{-8'sd128, 8'sd0}, '{8'sd127, 8'sd0}};
        aw_mem = '{'{8'sd100, 8'sd100}, '{8'sd0, 8'sd0}};
        bw_mem = '{'{8'sd1, 8'sd0}, '{8'sd1, 8'sd0}};
        test_reset();
        test_identity();
        test_backpressure();
        test_read_latency();
        test_abort_restart();
        test_signed();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1);
    end

endmodule

// File: doc/seq_matmul_mac.md
Name: seq_matmul_mac

Overview:
- Parametrised successor to the fixed square floating-point sequential multiplier: computes Z[MxN] = A[MxK] * B[KxN] on signed fixed-point integers.
- Uses a single-cycle internal MAC in place of handshaked float units.
- Reads operands from external synchronous memories via index ports with configurable read latency.
- Streams each finished Z element out on a strobe/ack handshake and sits between operand RAMs and a result sink.

Parameters:
- M, 4, rows of A and Z (>=1)
- K, 4, inner dimension (>=1)
- N, 4, columns of B and Z (>=1)
- DW, 16, operand width, signed two's complement
- OW, 2*DW+$clog2(K)+1, result width on z_out
- RD_LAT, 1, cycles from a_rd to valid a_in/b_in (>=1)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous reset, active-high
- start  in  1  begin a product; sampled only in IDLE
- a_rd  out  1  read strobe for both operand memories
- a_i  out  IM  row index into A (IM = max(1,$clog2(M)))
- a_j  out  IK  column index into A (IK = max(1,$clog2(K)))
- b_i  out  IK  row index into B
- b_j  out  IN  column index into B (IN = max(1,$clog2(N)))
- a_in  in  DW  A[a_i][a_j], valid RD_LAT cycles after a_rd
- b_in  in  DW  B[b_i][b_j], valid RD_LAT cycles after a_rd
- z_out  out  OW  result element
- z_i  out  IM  result row
- z_j  out  IN  result column
- z_stb  out  1  z_out/z_i/z_j valid
- z_ack  in  1  sink accepts element
- z_sat  out  1  element was clamped (MATMUL_SAT_EN only, else 0)
- busy  out  1  high outside IDLE
- done  out  1  one-cycle pulse at end of product

Behaviour:
- Reset, asynchronous on rst=1:
  - state=IDLE; i, j, k and acc = 0.
  - All outputs 0: a_rd, z_stb, z_out, z_sat, busy, done, and all index ports.
  - Asserting rst mid-operation aborts immediately with no partial output. The sink must discard any element that was not acked.
- States: IDLE, FETCH, WAIT, MAC, OUT, DONE.
- IDLE:
  - start=1 -> FETCH; i, j, k and acc are cleared.
  - start is ignored in every other state.
- FETCH (1 cycle):
  - a_rd=1, with a_i=i, a_j=k, b_i=k, b_j=j.
  - -> WAIT if RD_LAT>1, else -> MAC.
- WAIT:
  - Lasts RD_LAT-1 cycles; a_rd=0, index ports held.
  - A down-counter is loaded on entry.
- MAC (1 cycle):
  - Samples a_in and b_in and computes acc <= acc + sext(a_in)*sext(b_in) at full accumulator width 2*DW+$clog2(K)+1.
  - If k<K-1: k++ and -> FETCH.
  - Else: -> OUT, loading z_out from the updated sum and setting z_i=i, z_j=j.
- OUT:
  - z_stb=1; z_out, z_i and z_j stay stable until z_ack=1 is sampled.
  - On ack: z_stb=0, acc=0, k=0, then advance j. On j wrap, advance i.
  - -> FETCH, or -> DONE if i=M-1 and j=N-1.
  - z_ack while z_stb=0 has no effect.
- DONE: done=1 for one cycle, then -> IDLE, with busy=0 from the next cycle.
- Element order: row-major, with j fastest.
- Cycle counts:
  - Each element takes K*(RD_LAT+1) cycles plus handshake cycles, with a minimum of 1 OUT cycle.
  - With z_ack tied high, a full product takes M*N*(K*(RD_LAT+1)+1)+1 cycles from the start edge to the done pulse.
- Output width:
  - If OW is smaller than the accumulator width, z_out takes the low OW bits (wrap), unless saturation is compiled in.
  - If OW is larger, z_out is sign-extended.
- Degenerate sizes: M=1, K=1 or N=1 are legal; index ports stay 0.

Optional Feature:
- Macro: MATMUL_SAT_EN.
- When defined:
  - On entry to OUT the sum is clamped to [-2^(OW-1), 2^(OW-1)-1].
  - z_sat=1 alongside z_stb whenever clamping occurred.
- When undefined:
  - Wrap truncation applies.
  - z_sat is tied to 0.
  - No comparator logic is generated.

Decomposition:
- Package matmul_pkg:
  - State enum typedef.
  - Function idx_w(n) = max(1,$clog2(n)).
  - Function acc_w(dw,k) = 2*dw+$clog2(k)+1.
- Sub-module matmul_mac_acc:
  - Signed multiply-accumulate register with clear, enable and optional saturating read-out.
  - Instantiated once.

Test Plan:
- Identity test: M=K=N=2, RD_LAT=1, A=[[1,2],[3,4]], B=identity, z_ack high -> stream (0,0)=1, (0,1)=2, (1,0)=3, (1,1)=4; done on cycle 21 after start.
- Signed values: DW=8, A=[[-128,127]], B=[[-128],[127]] (M=1, K=2, N=1) -> z_out=16384+16129=32513, no wrap.
- Backpressure: hold z_ack low for 5 cycles on element (0,1) -> z_stb stays high, z_out/z_i/z_j unchanged, and no a_rd is issued until the ack.
- Read latency: RD_LAT=3 with a memory model returning data exactly 3 cycles after a_rd -> results match the RD_LAT=1 run; per-element spacing is K*4+1 cycles.
- Abort and restart: pulse rst during MAC of element (1,0), then start again -> all outputs 0 during reset; the new run emits (0,0) first with correct values; start pulses while busy are ignored.
- Saturation (MATMUL_SAT_EN): OW=8, A=[[100,100]], B=[[1],[1]] -> z_out=127, z_sat=1. Without the macro the same input gives z_out=-56 (0xC8) and z_sat=0.
